// File: rtl/dmem_mmio_bridge.sv
// Data-side bridge: decodes CPU data accesses into a data-memory window and an
// 8-word MMIO register file. Optional access-fault capture under BRIDGE_FAULT_EN.
module dmem_mmio_bridge #(
    parameter logic [31:0] DM_BASE  = 32'h1001_0000,
    parameter int          DM_WORDS = 2048,
    parameter logic [31:0] IO_BASE  = 32'h1002_0000,
    parameter int          SW_W     = 16,
    localparam int         AW       = $clog2(DM_WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     cpu_addr,
    input  logic            cpu_we,
    input  logic            cpu_re,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    output logic [AW-1:0]   dm_addr,
    output logic            dm_we,
    output logic            dm_re,
    output logic [31:0]     dm_wdata,
    input  logic [31:0]     dm_rdata,
    input  logic [SW_W-1:0] sw_in,
    output logic [31:0]     disp_data,
    output logic [SW_W-1:0] led_out,
    output logic            fault
);

    localparam logic [32:0] DM_END = {1'b0, DM_BASE} + 33'(DM_WORDS) * 33'd4;
    localparam logic [32:0] IO_END = {1'b0, IO_BASE} + 33'h20;

    localparam logic [2:0] OFF_DISP  = 3'd0;
    localparam logic [2:0] OFF_LED   = 3'd1;
    localparam logic [2:0] OFF_SW    = 3'd2;
    localparam logic [2:0] OFF_CYCLE = 3'd3;
    localparam logic [2:0] OFF_FAULT = 3'd4;
    localparam logic [2:0] OFF_FADDR = 3'd5;

    logic            dm_hit;
    logic            io_hit;
    logic            acc_bad;
    logic            io_wr;
    logic [31:0]     dm_off;
    logic [31:0]     io_rel;
    logic [2:0]      io_idx;
    logic [31:0]     io_rdata;

    logic [31:0]     disp_q, disp_d;
    logic [SW_W-1:0] led_q, led_d;
    logic [SW_W-1:0] sw_meta_q, sw_meta_d;
    logic [SW_W-1:0] sw_sync_q, sw_sync_d;
    logic [31:0]     cyc_q, cyc_d;
    logic            fault_rd;
    logic [31:0]     faddr_rd;

    // DM decode takes priority, so an overlapping IO window never double-hits.
    assign dm_hit = ({1'b0, cpu_addr} >= {1'b0, DM_BASE}) && ({1'b0, cpu_addr} < DM_END);
    assign io_hit = !dm_hit && ({1'b0, cpu_addr} >= {1'b0, IO_BASE}) && ({1'b0, cpu_addr} < IO_END);

    assign dm_off  = cpu_addr - DM_BASE;
    assign io_rel  = cpu_addr - IO_BASE;
    assign io_idx  = io_rel[4:2];
    assign dm_addr = dm_off[AW+1:2];

    logic unused_bits;
    assign unused_bits = ^{dm_off[1:0], dm_off[31:AW+2], io_rel[1:0], io_rel[31:5]};

    assign dm_we    = dm_hit && cpu_we && !acc_bad;
    assign dm_re    = dm_hit && cpu_re && !acc_bad;
    assign dm_wdata = cpu_wdata;
    assign io_wr    = io_hit && cpu_we && !acc_bad;

    assign disp_data = disp_q;
    assign led_out   = led_q;

`ifdef BRIDGE_FAULT_EN
    logic        fault_q, fault_d;
    logic [31:0] faddr_q, faddr_d;

    assign acc_bad  = (cpu_we || cpu_re) && (!(dm_hit || io_hit) || (cpu_addr[1:0] != 2'b00));
    assign fault    = fault_q;
    assign fault_rd = fault_q;
    assign faddr_rd = faddr_q;

    // A new fault is applied after the clear so it wins in the same cycle.
    always_comb begin
        fault_d = fault_q;
        faddr_d = faddr_q;
        if (io_wr && io_idx == OFF_FAULT && cpu_wdata[0]) begin
            fault_d = 1'b0;
        end
        if (acc_bad) begin
            fault_d = 1'b1;
            if (!fault_q) begin
                faddr_d = cpu_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
            faddr_q <= '0;
        end else begin
            fault_q <= fault_d;
            faddr_q <= faddr_d;
        end
    end
`else
    assign acc_bad  = 1'b0;
    assign fault    = 1'b0;
    assign fault_rd = 1'b0;
    assign faddr_rd = '0;
`endif

    always_comb begin
        disp_d    = disp_q;
        led_d     = led_q;
        sw_meta_d = sw_in;
        sw_sync_d = sw_meta_q;
        cyc_d     = cyc_q + 32'd1;
        if (io_wr) begin
            case (io_idx)
                OFF_DISP:  disp_d = cpu_wdata;
                OFF_LED:   led_d  = cpu_wdata[SW_W-1:0];
                OFF_CYCLE: cyc_d  = '0;
                default:   ;
            endcase
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_idx)
            OFF_DISP:  io_rdata = disp_q;
            OFF_LED:   io_rdata[SW_W-1:0] = led_q;
            OFF_SW:    io_rdata[SW_W-1:0] = sw_sync_q;
            OFF_CYCLE: io_rdata = cyc_q;
            OFF_FAULT: io_rdata[0] = fault_rd;
            OFF_FADDR: io_rdata = faddr_rd;
            default:   io_rdata = '0;
        endcase
    end

    // Reads always return the pre-edge register value, including on store+load.
    always_comb begin
        cpu_rdata = '0;
        if (!acc_bad) begin
            if (dm_hit) begin
                cpu_rdata = dm_rdata;
            end else if (io_hit) begin
                cpu_rdata = io_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q    <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cyc_q     <= '0;
        end else begin
            disp_q    <= disp_d;
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            cyc_q     <= cyc_d;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Scoreboard bench for dmem_mmio_bridge (default parameters).
module tb_dmem_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, dm_wdata, dm_rdata, disp_data;
    logic        cpu_we, cpu_re, dm_we, dm_re, fault;
    logic [10:0] dm_addr;
    logic [15:0] sw_in, led_out;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    logic [31:0] got;
    int          vec_cnt = 0;
    int          err_cnt = 0;

    always #5 clk = ~clk;

    dmem_mmio_bridge dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_re(dm_re),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .sw_in(sw_in), .disp_data(disp_data), .led_out(led_out), .fault(fault)
    );

    task automatic drive(input logic [31:0] a, input logic we, input logic re, input logic [31:0] wd);
        cpu_addr  = a;
        cpu_we    = we;
        cpu_re    = re;
        cpu_wdata = wd;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        drive(32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(32'h1002_000C, 1'b0, 1'b1, 32'h0);
        sb_q.push_back('{"rst_disp", 32'h0});
        sb_q.push_back('{"rst_led", 32'h0});
        sb_q.push_back('{"rst_cycle", 32'h0});
        sb_q.push_back('{"rst_fault", 32'h0});
        #1;
        got = disp_data; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = {16'h0, led_out}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = {31'h0, fault}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
    endtask

    task automatic test_dm();
        next_cycle();
        drive(32'h1001_0008, 1'b1, 1'b0, 32'hDEAD_BEEF);
        sb_q.push_back('{"dm_st_addr", 32'd2});
        sb_q.push_back('{"dm_st_we", 32'd1});
        sb_q.push_back('{"dm_st_wdata", 32'hDEAD_BEEF});
        #1;
        got = {21'h0, dm_addr}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = {31'h0, dm_we}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = dm_wdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        next_cycle();
        drive(32'h1001_0008, 1'b0, 1'b1, 32'h0);
        dm_rdata = 32'hDEAD_BEEF;
        sb_q.push_back('{"dm_ld_re", 32'd1});
        sb_q.push_back('{"dm_ld_rdata", 32'hDEAD_BEEF});
        #1;
        got = {31'h0, dm_re}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        // Last word in the window, then the first address past it.
        next_cycle();
        drive(32'h1001_1FFC, 1'b0, 1'b1, 32'h0);
        sb_q.push_back('{"dm_top_addr", 32'h7FF});
        #1;
        got = {21'h0, dm_addr}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        next_cycle();
        drive(32'h1001_2000, 1'b1, 1'b1, 32'h1);
        sb_q.push_back('{"dm_end_strobes", 32'h0});
        sb_q.push_back('{"dm_end_rdata", 32'h0});
        #1;
        got = {30'h0, dm_we, dm_re}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
    endtask

    task automatic test_disp_led();
        next_cycle();
        drive(32'h1002_0000, 1'b1, 1'b0, 32'h0012_3456);
        sb_q.push_back('{"disp_before_edge", 32'h0});
        sb_q.push_back('{"disp_after_edge", 32'h0012_3456});
        sb_q.push_back('{"disp_readback", 32'h0012_3456});
        #1;
        got = disp_data; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        next_cycle();
        drive(32'h1002_0000, 1'b0, 1'b1, 32'h0);
        #1;
        got = disp_data; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        next_cycle();
        drive(32'h1002_0004, 1'b1, 1'b0, 32'hFFFF_FFFF);
        next_cycle();
        drive(32'h1002_0004, 1'b0, 1'b1, 32'h0);
        sb_q.push_back('{"led_out", 32'h0000_FFFF});
        sb_q.push_back('{"led_readback", 32'h0000_FFFF});
        #1;
        got = {16'h0, led_out}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        // Asynchronous reset while a write is pending: write lost, regs cleared at once.
        drive(32'h1002_0000, 1'b1, 1'b0, 32'h7777_7777);
        #1 rst = 1'b1;
        sb_q.push_back('{"disp_async_rst", 32'h0});
        sb_q.push_back('{"led_async_rst", 32'h0});
        #1;
        got = disp_data; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = {16'h0, led_out}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        @(negedge clk);
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
    endtask

    task automatic test_sw();
        next_cycle();
        sw_in = 16'hA5A5;
        drive(32'h1002_0008, 1'b0, 1'b1, 32'h0);
        sb_q.push_back('{"sw_edge0", 32'h0});
        sb_q.push_back('{"sw_edge1", 32'h0});
        sb_q.push_back('{"sw_edge2", 32'h0000_A5A5});
        sb_q.push_back('{"sw_write_ignored", 32'h0000_A5A5});
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        @(negedge clk); #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        @(negedge clk); #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        drive(32'h1002_0008, 1'b1, 1'b0, 32'h0000_1234);
        @(negedge clk);
        drive(32'h1002_0008, 1'b0, 1'b1, 32'h0);
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
    endtask

    task automatic test_cycle();
        do_reset();
        drive(32'h1002_000C, 1'b0, 1'b1, 32'h0);
        repeat (10) @(negedge clk);
        sb_q.push_back('{"cycle_10", 32'd10});
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        drive(32'h1002_000C, 1'b1, 1'b0, 32'h0000_1234);
        @(negedge clk);
        drive(32'h1002_000C, 1'b0, 1'b1, 32'h0);
        sb_q.push_back('{"cycle_cleared", 32'd0});
        sb_q.push_back('{"cycle_after_clear", 32'd1});
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        @(negedge clk); #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        @(negedge clk);
        force dut.cyc_q = 32'hFFFF_FFFF;
        sb_q.push_back('{"cycle_forced", 32'hFFFF_FFFF});
        sb_q.push_back('{"cycle_wrap", 32'h0});
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        release dut.cyc_q;
        @(negedge clk); #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
    endtask

    task automatic test_miss_reserved();
        next_cycle();
        drive(32'h1002_0000, 1'b1, 1'b0, 32'hCAFE_0001);
        next_cycle();
        dm_rdata = 32'h5555_5555;
        drive(32'h2000_0000, 1'b1, 1'b1, 32'h1111_1111);
        sb_q.push_back('{"miss_strobes", 32'h0});
        sb_q.push_back('{"miss_rdata", 32'h0});
        sb_q.push_back('{"miss_disp_kept", 32'hCAFE_0001});
        #1;
        got = {30'h0, dm_we, dm_re}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        next_cycle(); #1;
        got = disp_data; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        drive(32'h1002_0018, 1'b1, 1'b1, 32'hFFFF_FFFF);
        sb_q.push_back('{"reserved_rdata", 32'h0});
        sb_q.push_back('{"io_end_rdata", 32'h0});
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        next_cycle();
        drive(32'h1002_0020, 1'b0, 1'b1, 32'h0);
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        // Store and load together: the load sees the value before the store lands.
        next_cycle();
        drive(32'h1002_0000, 1'b1, 1'b1, 32'hBEEF_0002);
        sb_q.push_back('{"rw_pre_value", 32'hCAFE_0001});
        sb_q.push_back('{"rw_post_value", 32'hBEEF_0002});
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        next_cycle(); #1;
        got = disp_data; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h0000_0011; vals[1] = 32'h2222_0000;
        vals[2] = 32'h3333_3333; vals[3] = 32'h0404_0404;
        next_cycle();
        drive(32'h1002_0000, 1'b1, 1'b0, vals[0]);
        sb_q.push_back('{"b2b_disp", vals[0]});
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            drive(32'h1002_0000, 1'b1, 1'b0, vals[i]);
            sb_q.push_back('{"b2b_disp", vals[i]});
            #1;
            got = disp_data; e = sb_q.pop_front(); vec_cnt++;
            if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        end
        next_cycle(); #1;
        got = disp_data; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
    endtask

`ifdef BRIDGE_FAULT_EN
    task automatic test_fault();
        next_cycle();
        drive(32'h1002_0010, 1'b1, 1'b0, 32'h1);
        next_cycle(); #1;
        sb_q.push_back('{"fault_cleared0", 32'h0});
        got = {31'h0, fault}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        drive(32'h1001_0002, 1'b0, 1'b1, 32'h0);
        dm_rdata = 32'h9999_9999;
        sb_q.push_back('{"misalign_dm_re", 32'h0});
        sb_q.push_back('{"misalign_rdata", 32'h0});
        sb_q.push_back('{"fault_set", 32'h1});
        sb_q.push_back('{"faddr_first", 32'h1001_0002});
        #1;
        got = {31'h0, dm_re}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        next_cycle();
        drive(32'h1002_0014, 1'b0, 1'b1, 32'h0);
        #1;
        got = {31'h0, fault}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        next_cycle();
        drive(32'h3000_0000, 1'b1, 1'b0, 32'h5);
        next_cycle();
        drive(32'h1002_0014, 1'b0, 1'b1, 32'h0);
        sb_q.push_back('{"faddr_kept", 32'h1001_0002});
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end

        next_cycle();
        drive(32'h1002_0010, 1'b1, 1'b0, 32'h1);
        next_cycle();
        drive(32'h1002_0010, 1'b0, 1'b1, 32'h0);
        sb_q.push_back('{"fault_clear", 32'h0});
        sb_q.push_back('{"fault_reg_read", 32'h0});
        #1;
        got = {31'h0, fault}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
    endtask
`else
    task automatic test_fault();
        next_cycle();
        drive(32'h1001_0002, 1'b0, 1'b1, 32'h0);
        sb_q.push_back('{"noflt_dm_re", 32'h1});
        sb_q.push_back('{"noflt_dm_addr", 32'h0});
        #1;
        got = {31'h0, dm_re}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = {21'h0, dm_addr}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        next_cycle();
        drive(32'h1002_0010, 1'b1, 1'b1, 32'hFFFF_FFFF);
        sb_q.push_back('{"noflt_fault", 32'h0});
        sb_q.push_back('{"noflt_reg10", 32'h0});
        sb_q.push_back('{"noflt_reg14", 32'h0});
        #1;
        got = {31'h0, fault}; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
        next_cycle();
        drive(32'h1002_0014, 1'b0, 1'b1, 32'h0);
        #1;
        got = cpu_rdata; e = sb_q.pop_front(); vec_cnt++;
        if (got !== e.exp) begin err_cnt++; $display("FAIL %s got=%h exp=%h", e.tag, got, e.exp); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        sw_in    = '0;
        dm_rdata = '0;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_dm();
        test_disp_led();
        test_sw();
        test_cycle();
        test_miss_reserved();
        test_back_to_back();
        test_fault();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
